// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// from execute, and the valid/ready path to the decoder.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  // Memory / execute / decoder side
  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to a
// one-cycle synchronous memory, buffers {instr, pc} in a small FIFO and
// hands them to decode over valid/ready. A redirect flushes everything.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   pc_q;
  logic [31:0]   inflight_pc_q;
  logic          inflight_q;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occupancy;
  logic          unused_pc_bits;

  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready;
  // A response lands the cycle after its request, so its slot is reserved
  // at issue time; this keeps the FIFO from ever overflowing.
  assign occupancy = OW'(count) + OW'(inflight_q) - OW'(pop);
  assign issue     = rst_n & ~bus.redirect & (occupancy < OW'(FIFO_DEPTH));
  // A response arriving in a redirect cycle belongs to the old path.
  assign push      = inflight_q & ~bus.redirect;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? mem[rd_ptr].instr : '0;
  assign bus.out_pc    = valid ? mem[rd_ptr].pc    : '0;

  // Low address bits of the target are dropped to keep fetch word-aligned.
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Fetch PC and in-flight request tracking; redirect overrides issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (bus.redirect) begin
      pc_q       <= {bus.redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: inflight_pc_q};
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
